// File: rtl/dm9000a_bus_arbiter.sv
// Round-robin owner arbiter that hands the whole DM9000A primitive engine bank to one client sequencer.
// Optional ownership watchdog built in with `define DM9000A_ARB_WDOG_EN.
//
// state      | meaning
// ST_IDLE    | no owner, engine commands forced low, scanning requests from rr_ptr
// ST_GRANT   | one client owns every engine; its commands are muxed through
// ST_RELEASE | owner gone, commands held low for one cycle, rr_ptr advanced
module dm9000a_bus_arbiter #(
  parameter int NCLI     = 3,
  parameter int IDX_W    = 2,
  parameter int WDOG_CYC = 65535
) (
  input  logic                iDm9000aClk,
  input  logic                iRst,
  input  logic [NCLI-1:0]     iReq,
  output logic [NCLI-1:0]     oGrant,
  output logic [IDX_W-1:0]    oOwner,

  input  logic [NCLI-1:0]     iCli_Iow_RunStart,
  input  logic [16*NCLI-1:0]  iCli_Iow_Reg,
  input  logic [16*NCLI-1:0]  iCli_Iow_Data,
  input  logic [NCLI-1:0]     iCli_IOWR_RunStart,
  input  logic [NCLI-1:0]     iCli_IOWR_IndexOrData,
  input  logic [16*NCLI-1:0]  iCli_IOWR_OutData,
  input  logic [NCLI-1:0]     iCli_Ior_RunStart,
  input  logic [16*NCLI-1:0]  iCli_Ior_iReg,
  input  logic [NCLI-1:0]     iCli_usDelay_RunStart,
  input  logic [11*NCLI-1:0]  iCli_usDelay_DelayTime,

  output logic                out_to_Dm9000a_Iow_RunStart,
  output logic [15:0]         out_to_Dm9000a_Iow_Reg,
  output logic [15:0]         out_to_Dm9000a_Iow_Data,
  output logic                out_to_Dm9000a_IOWR_RunStart,
  output logic                out_to_Dm9000a_IOWR_IndexOrData,
  output logic [15:0]         out_to_Dm9000a_IOWR_OutData,
  output logic                out_to_Dm9000a_Ior_RunStart,
  output logic [15:0]         out_to_Dm9000a_Ior_iReg,
  output logic                out_to_Dm9000a_usDelay_RunStart,
  output logic [10:0]         out_to_Dm9000a_usDelay_DelayTime,

  input  logic                in_from_Dm9000a_Iow_RunEnd,
  input  logic                in_from_Dm9000a_Ior_RunEnd,
  input  logic                in_from_Dm9000a_IOWR_RunEnd,
  input  logic                in_from_Dm9000a_usDelay_RunEnd,
  input  logic [15:0]         in_from_Dm9000a_Ior_ReturnValue,

  output logic [NCLI-1:0]     oCli_Iow_RunEnd,
  output logic [NCLI-1:0]     oCli_Ior_RunEnd,
  output logic [NCLI-1:0]     oCli_IOWR_RunEnd,
  output logic [NCLI-1:0]     oCli_usDelay_RunEnd,
  output logic [15:0]         oCli_Ior_ReturnValue,
  output logic                oWdogErr
);

  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NCLI-1:0]   grant_q, grant_d;
  logic [NCLI-1:0]   req_eff;
  logic              owner_req;
  logic              force_rel;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [CW-1:0]     cand;

`ifdef DM9000A_ARB_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYC);

  logic [15:0]       wdog_cnt_q, wdog_cnt_d, wdog_inc;
  logic              wdog_err_q, wdog_err_d;
  logic [NCLI-1:0]   blocked_q, blocked_d;

  // A client evicted by the watchdog stays masked until it lets go of iReq.
  always_comb begin
    wdog_inc   = (wdog_cnt_q == 16'hFFFF) ? wdog_cnt_q : wdog_cnt_q + 16'd1;
    force_rel  = (state_q == ST_GRANT) && (wdog_inc >= WDOG_LIM);
    wdog_cnt_d = wdog_cnt_q;
    if (state_q == ST_IDLE) begin
      wdog_cnt_d = '0;
    end else if (state_q == ST_GRANT) begin
      wdog_cnt_d = wdog_inc;
    end
    wdog_err_d = wdog_err_q | force_rel;
    blocked_d  = blocked_q & iReq;
    if (force_rel) begin
      blocked_d = blocked_d | grant_q;
    end
    req_eff = iReq & ~blocked_q;
  end

  always_ff @(posedge iDm9000aClk) begin
    if (iRst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
      blocked_q  <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
      blocked_q  <= blocked_d;
    end
  end

  assign oWdogErr = wdog_err_q;
`else
  assign force_rel = 1'b0;
  assign req_eff   = iReq;
  assign oWdogErr  = 1'b0;
`endif

  // First requester at or after rr_ptr, wrapping modulo NCLI.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NCLI; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NCLI)) begin
        cand = cand - CW'(NCLI);
      end
      if (!pick_found && req_eff[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign owner_req = |(iReq & grant_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          grant_d = NCLI'(1) << pick_idx;
        end
      end
      ST_GRANT: begin
        if (!owner_req || force_rel) begin
          state_d = ST_RELEASE;
          grant_d = '0;
        end
      end
      ST_RELEASE: begin
        rr_ptr_d = (owner_q == IDX_W'(NCLI - 1)) ? '0 : owner_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge iDm9000aClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  assign oGrant = grant_q;
  assign oOwner = owner_q;

  // grant_q is one-hot in GRANT and zero elsewhere, so it doubles as the mux select.
  always_comb begin
    out_to_Dm9000a_Iow_RunStart      = 1'b0;
    out_to_Dm9000a_Iow_Reg           = '0;
    out_to_Dm9000a_Iow_Data          = '0;
    out_to_Dm9000a_IOWR_RunStart     = 1'b0;
    out_to_Dm9000a_IOWR_IndexOrData  = 1'b0;
    out_to_Dm9000a_IOWR_OutData      = '0;
    out_to_Dm9000a_Ior_RunStart      = 1'b0;
    out_to_Dm9000a_Ior_iReg          = '0;
    out_to_Dm9000a_usDelay_RunStart  = 1'b0;
    out_to_Dm9000a_usDelay_DelayTime = '0;
    for (int k = 0; k < NCLI; k++) begin
      if (grant_q[k]) begin
        out_to_Dm9000a_Iow_RunStart      = iCli_Iow_RunStart[k];
        out_to_Dm9000a_Iow_Reg           = iCli_Iow_Reg[16*k +: 16];
        out_to_Dm9000a_Iow_Data          = iCli_Iow_Data[16*k +: 16];
        out_to_Dm9000a_IOWR_RunStart     = iCli_IOWR_RunStart[k];
        out_to_Dm9000a_IOWR_IndexOrData  = iCli_IOWR_IndexOrData[k];
        out_to_Dm9000a_IOWR_OutData      = iCli_IOWR_OutData[16*k +: 16];
        out_to_Dm9000a_Ior_RunStart      = iCli_Ior_RunStart[k];
        out_to_Dm9000a_Ior_iReg          = iCli_Ior_iReg[16*k +: 16];
        out_to_Dm9000a_usDelay_RunStart  = iCli_usDelay_RunStart[k];
        out_to_Dm9000a_usDelay_DelayTime = iCli_usDelay_DelayTime[11*k +: 11];
      end
    end
  end

  assign oCli_Iow_RunEnd      = grant_q & {NCLI{in_from_Dm9000a_Iow_RunEnd}};
  assign oCli_Ior_RunEnd      = grant_q & {NCLI{in_from_Dm9000a_Ior_RunEnd}};
  assign oCli_IOWR_RunEnd     = grant_q & {NCLI{in_from_Dm9000a_IOWR_RunEnd}};
  assign oCli_usDelay_RunEnd  = grant_q & {NCLI{in_from_Dm9000a_usDelay_RunEnd}};
  assign oCli_Ior_ReturnValue = in_from_Dm9000a_Ior_ReturnValue;

endmodule

// File: tb/tb_dm9000a_bus_arbiter.sv
// Directed bench for dm9000a_bus_arbiter: per-cycle vector table plus hand-written handover,
// reset and watchdog sequences.
module tb_dm9000a_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req, iow_st, iowr_st, iowr_iod, ior_st, usd_st;
  logic [47:0] iow_reg, iow_data, iowr_data, ior_reg;
  logic [32:0] usd_time;
  logic        e_iow_end, e_ior_end, e_iowr_end, e_usd_end;
  logic [15:0] e_ret;

  logic [2:0]  grant;
  logic [1:0]  owner;
  logic        o_iow_st, o_iowr_st, o_iowr_iod, o_ior_st, o_usd_st;
  logic [15:0] o_iow_reg, o_iow_data, o_iowr_data, o_ior_reg;
  logic [10:0] o_usd_time;
  logic [2:0]  c_iow_end, c_ior_end, c_iowr_end, c_usd_end;
  logic [15:0] c_ret;
  logic        wdog_err;

  int checks = 0;
  int errors = 0;

  dm9000a_bus_arbiter #(.NCLI(3), .IDX_W(2), .WDOG_CYC(20)) dut (
    .iDm9000aClk                     (clk),
    .iRst                            (rst),
    .iReq                            (req),
    .oGrant                          (grant),
    .oOwner                          (owner),
    .iCli_Iow_RunStart               (iow_st),
    .iCli_Iow_Reg                    (iow_reg),
    .iCli_Iow_Data                   (iow_data),
    .iCli_IOWR_RunStart              (iowr_st),
    .iCli_IOWR_IndexOrData           (iowr_iod),
    .iCli_IOWR_OutData               (iowr_data),
    .iCli_Ior_RunStart               (ior_st),
    .iCli_Ior_iReg                   (ior_reg),
    .iCli_usDelay_RunStart           (usd_st),
    .iCli_usDelay_DelayTime          (usd_time),
    .out_to_Dm9000a_Iow_RunStart     (o_iow_st),
    .out_to_Dm9000a_Iow_Reg          (o_iow_reg),
    .out_to_Dm9000a_Iow_Data         (o_iow_data),
    .out_to_Dm9000a_IOWR_RunStart    (o_iowr_st),
    .out_to_Dm9000a_IOWR_IndexOrData (o_iowr_iod),
    .out_to_Dm9000a_IOWR_OutData     (o_iowr_data),
    .out_to_Dm9000a_Ior_RunStart     (o_ior_st),
    .out_to_Dm9000a_Ior_iReg         (o_ior_reg),
    .out_to_Dm9000a_usDelay_RunStart (o_usd_st),
    .out_to_Dm9000a_usDelay_DelayTime(o_usd_time),
    .in_from_Dm9000a_Iow_RunEnd      (e_iow_end),
    .in_from_Dm9000a_Ior_RunEnd      (e_ior_end),
    .in_from_Dm9000a_IOWR_RunEnd     (e_iowr_end),
    .in_from_Dm9000a_usDelay_RunEnd  (e_usd_end),
    .in_from_Dm9000a_Ior_ReturnValue (e_ret),
    .oCli_Iow_RunEnd                 (c_iow_end),
    .oCli_Ior_RunEnd                 (c_ior_end),
    .oCli_IOWR_RunEnd                (c_iowr_end),
    .oCli_usDelay_RunEnd             (c_usd_end),
    .oCli_Ior_ReturnValue            (c_ret),
    .oWdogErr                        (wdog_err)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req, iow_st, ior_st;
    logic        iow_end, ior_end;
    logic [2:0]  grant;
    logic [1:0]  owner;
    logic        o_iow_st, o_ior_st;
    logic [15:0] iow_reg;
    logic [2:0]  c_iow_end, c_ior_end;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; iow_st = '0; iowr_st = '0; iowr_iod = '0; ior_st = '0; usd_st = '0;
    e_iow_end = 1'b0; e_ior_end = 1'b0; e_iowr_end = 1'b0; e_usd_end = 1'b0;
    e_ret = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (grant != 3'b000) break;
    end
  endtask

  function automatic logic [3:0] starts();
    return {o_iow_st, o_iowr_st, o_ior_st, o_usd_st};
  endfunction

  int n, hold, gap_bad;
  logic [2:0] cur;
  logic [2:0] exp_rr[3];

  initial begin
    rst = 1'b1;
    clear_inputs();
    iow_reg   = {16'h00A2, 16'h00FC, 16'h00A0};
    iow_data  = {16'h0022, 16'h0012, 16'h0002};
    iowr_data = '0;
    ior_reg   = {16'h0E02, 16'h0E01, 16'h0E00};
    usd_time  = '0;
    exp_rr    = '{3'b010, 3'b100, 3'b001};

    //            rst   req     iow_st  ior_st  iowE  iorE  grant   own   oIow  oIor  iow_reg    cIowE   cIorE
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000};
    tbl[2]  = '{1'b0, 3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, 16'h00FC, 3'b000, 3'b000};
    tbl[3]  = '{1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b0, 3'b010, 2'd1, 1'b0, 1'b0, 16'h00FC, 3'b010, 3'b000};
    tbl[4]  = '{1'b0, 3'b010, 3'b000, 3'b001, 1'b0, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0, 16'h00FC, 3'b000, 3'b010};
    tbl[5]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 2'd1, 1'b0, 1'b0, 16'h00FC, 3'b000, 3'b000};
    tbl[6]  = '{1'b0, 3'b101, 3'b101, 3'b000, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000};
    tbl[7]  = '{1'b0, 3'b101, 3'b101, 3'b000, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000};
    tbl[8]  = '{1'b0, 3'b101, 3'b101, 3'b000, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, 16'h00A2, 3'b100, 3'b000};
    tbl[9]  = '{1'b0, 3'b001, 3'b101, 3'b000, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, 16'h00A2, 3'b000, 3'b000};
    tbl[10] = '{1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 2'd2, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000};
    tbl[11] = '{1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000};
    tbl[12] = '{1'b0, 3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, 16'h00A0, 3'b000, 3'b000};
    tbl[13] = '{1'b0, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b0, 1'b1, 16'h00A0, 3'b000, 3'b000};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 14; i++) begin
      tick();
      rst       = tbl[i].rst;
      req       = tbl[i].req;
      iow_st    = tbl[i].iow_st;
      ior_st    = tbl[i].ior_st;
      e_iow_end = tbl[i].iow_end;
      e_ior_end = tbl[i].ior_end;
      #1;
      chk($sformatf("v%0d_grant", i),    grant,     tbl[i].grant);
      chk($sformatf("v%0d_owner", i),    owner,     tbl[i].owner);
      chk($sformatf("v%0d_iow_st", i),   o_iow_st,  tbl[i].o_iow_st);
      chk($sformatf("v%0d_ior_st", i),   o_ior_st,  tbl[i].o_ior_st);
      chk($sformatf("v%0d_iow_reg", i),  o_iow_reg, tbl[i].iow_reg);
      chk($sformatf("v%0d_cli_iow", i),  c_iow_end, tbl[i].c_iow_end);
      chk($sformatf("v%0d_cli_ior", i),  c_ior_end, tbl[i].c_ior_end);
    end

    // Round-robin with all three requesting, each owner holding 5 cycles.
    do_reset();
    req = 3'b111; iow_st = 3'b111; iowr_st = 3'b111; ior_st = 3'b111; usd_st = 3'b111;
    wait_grant(8, n);
    chk("rr_latency", n, 1);
    chk("rr_grant_first", grant, 3'b001);
    chk("rr_iow_data", o_iow_data, 16'h0002);
    for (int g = 0; g < 3; g++) begin
      cur  = grant;
      hold = 1;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (grant == cur) hold++;
      end
      chk("rr_hold", hold, 5);
      req     = req & ~cur;
      gap_bad = 0;
      n       = 0;
      while (n < 8) begin
        tick();
        n++;
        if (grant != 3'b000) break;
        if (starts() != 4'b0000) gap_bad++;
      end
      chk("rr_handover", n, 3);
      chk("rr_gap_starts", gap_bad, 0);
      chk("rr_grant", grant, exp_rr[g]);
      chk("rr_start_on", starts(), 4'b1111);
      req = 3'b111;
    end

    // Owner 0 while client 2 toggles Ior start; read data is broadcast.
    do_reset();
    usd_time[10:0] = 11'h123;
    req = 3'b001; usd_st = 3'b001; ior_st = 3'b100; e_ret = 16'h0040;
    wait_grant(8, n);
    chk("nonown_grant", grant, 3'b001);
    chk("nonown_usd_time", o_usd_time, 11'h123);
    chk("nonown_usd_st", o_usd_st, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ior_st    = k[0] ? 3'b000 : 3'b100;
      e_ior_end = 1'b1;
      e_usd_end = 1'b1;
      #1;
      chk("nonown_ior_st", o_ior_st, 1'b0);
      chk("nonown_ret", c_ret, 16'h0040);
      chk("nonown_ior_end", c_ior_end, 3'b001);
      chk("nonown_usd_end", c_usd_end, 3'b001);
      tick();
    end
    e_ior_end = 1'b0; e_usd_end = 1'b0;

    // Reset in the middle of client 1's IOWR transfer.
    do_reset();
    iowr_data = {16'hBBBB, 16'h1234, 16'hAAAA};
    req = 3'b010; iowr_st = 3'b010; iowr_iod = 3'b010;
    wait_grant(8, n);
    chk("rst_grant", grant, 3'b010);
    chk("rst_iowr_st", o_iowr_st, 1'b1);
    chk("rst_iowr_iod", o_iowr_iod, 1'b1);
    chk("rst_iowr_data", o_iowr_data, 16'h1234);
    rst = 1'b1;
    tick();
    chk("rst_grant_drop", grant, 3'b000);
    chk("rst_starts", starts(), 4'b0000);
    chk("rst_iowr_data0", o_iowr_data, 16'h0000);
    chk("rst_iowr_iod0", o_iowr_iod, 1'b0);
    rst = 1'b0; req = 3'b110; iowr_st = 3'b000;
    wait_grant(8, n);
    chk("rst_post_grant", grant, 3'b010);

    // Single-cycle request pulse from client 0.
    do_reset();
    req = 3'b001;
    tick();
    chk("pulse_grant", grant, 3'b001);
    chk("pulse_starts", starts(), 4'b0000);
    req = 3'b000;
    tick();
    chk("pulse_release", grant, 3'b000);
    chk("pulse_rel_starts", starts(), 4'b0000);
    tick();
    chk("pulse_idle", grant, 3'b000);
    tick();
    chk("pulse_stay_idle", grant, 3'b000);

`ifdef DM9000A_ARB_WDOG_EN
    // Client 0 overstays; client 2 waits behind it.
    do_reset();
    chk("wdog_reset", wdog_err, 1'b0);
    req = 3'b001;
    wait_grant(8, n);
    chk("wdog_grant0", grant, 3'b001);
    req  = 3'b101;
    hold = 1;
    while (hold < 40) begin
      tick();
      if (grant != 3'b001) break;
      hold++;
    end
    chk("wdog_grant_cycles", hold, 20);
    chk("wdog_err_set", wdog_err, 1'b1);
    n = 1;
    while (n < 8) begin
      tick();
      if (grant != 3'b000) break;
      n++;
    end
    chk("wdog_gap", n, 2);
    chk("wdog_next_owner", grant, 3'b100);
    req = 3'b001;
    repeat (6) tick();
    chk("wdog_blocked", grant, 3'b000);
    chk("wdog_sticky", wdog_err, 1'b1);
    req = 3'b000;
    tick();
    req = 3'b001;
    wait_grant(8, n);
    chk("wdog_regrant", grant, 3'b001);
`else
    // No watchdog: ownership is unbounded.
    do_reset();
    req = 3'b001;
    wait_grant(8, n);
    chk("nowdog_grant", grant, 3'b001);
    hold = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (grant == 3'b001) hold++;
    end
    chk("nowdog_hold", hold, 30);
    chk("nowdog_err", wdog_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench time limit expired");
  end

endmodule
